ring_token_arbiter: RTL and testbench
=====================================

# ring_token_arbiter

Round-robin arbiter that shares one resource among four requesters. A one-hot rotating priority token advances like a 4-bit ring counter. The block sits in front of the shared datapath, takes four request lines and issues at most one registered one-hot grant. Fairness comes from rotating the token past each winner. An optional hold timeout stops any requester from monopolising the resource.

## Interface
- MAX_HOLD, 8, maximum tenure in cycles before forced re-arbitration (timeout build only); legal range 2..255
- clock  input  1  system clock; all state updates on the rising edge
- reset  input  1  synchronous, active-high reset
- req  input  4  request lines; bit i = requester i; level-sensitive, held high for the whole tenure
- grant  output  4  registered one-hot grant, or 0000 when idle
- owner  output  2  index of the current grant holder; valid only while busy=1
- busy  output  1  high while grant is non-zero
- token  output  4  one-hot priority pointer; the requester it marks has highest priority at the next arbitration
- preempt  output  1  one-cycle pulse, asserted together with the grant change caused by a timeout

## Operation
- States:
  - IDLE: grant=0000.
  - HELD: exactly one grant bit is set.
- Arbitration function:
  - Start at the token position and scan upward with wrap (e.g. token 0100 → order 2,3,0,1).
  - The first bit with req=1 wins.
- IDLE:
  - If any req bit is 1: grant ← winner, owner ← its index, state → HELD, token ← winner rotated left by one (1000 wraps to 0001).
  - If no req bit is 1: nothing changes.
- HELD, with req[owner]=1 and no timeout: grant, owner and token are held.
- HELD, with req[owner]=0 sampled (release):
  - Arbitrate on the same edge. The old owner cannot win because its req is 0.
  - Winner found: grant switches directly to the new winner (no dead cycle), token updates as in IDLE.
  - No winner: grant ← 0000, state → IDLE, token is kept.
- Token only changes on an edge that issues a new grant.
- Simultaneous events: a release plus new requests on the same edge produce a direct handover. Requests that change while HELD have no effect until the next release or timeout.
- Reset:
  - Values: grant=0000, owner=00, busy=0, token=0001, preempt=0, hold counter=0, state IDLE.
  - Reset overrides req on the same edge and aborts any tenure in progress.

## Timing
- Request-to-grant latency from IDLE is one edge: req sampled high at edge k → grant visible after edge k.
- Release-to-handover latency is one edge: req[owner] sampled low at edge k → new grant (or 0000) after edge k.
- All outputs are registered. There are no combinational paths from req to any output.
- Hold counter:
  - Loads 0 on every edge that issues a grant.
  - Increments by 1 each HELD cycle.
  - 8-bit wide and saturating. It never wraps in the non-timeout build.
- First arbitration after reset deassertion occurs on the first edge with reset=0.

## Configuration
- Macro: RING_ARB_TIMEOUT_EN.
- Defined:
  - A timeout occurs on the edge where the hold counter equals MAX_HOLD-1 and req[owner] is still 1.
  - On that edge, arbitration excludes the owner. If another requester wins, grant hands over, token updates and preempt pulses high for exactly one cycle.
  - If no other requester is active, the owner keeps the grant, the counter reloads to 0 and preempt stays 0.
  - A tenure therefore lasts at most MAX_HOLD cycles while others are waiting.
- Undefined:
  - Tenure is unlimited and MAX_HOLD is ignored.
  - preempt is tied to 0. The hold counter may be removed.
  - Port list is identical in both builds.

## Test plan
- Reset: reset=1 for 2 edges with req=1111 → grant=0000, token=0001, busy=0. After reset drops, first edge → grant=0001, owner=0, token=0010.
- Basic arbitration and handover:
  - From idle with token 0001, req=1010 → grant=0010, token=0100.
  - Drop req[1] with req[3] still high → next edge grant=1000, token=0001, with no zero cycle in between.
- Wrap and go idle:
  - Token=1000, req=1001 → grant=1000, token=0001.
  - Drop req[3] → grant=0001.
  - Drop req[0] → grant=0000, busy=0, token=0010 kept.
- Timeout (macro defined, MAX_HOLD=4): req=0011 held from idle with token 0001 → grant=0001 for exactly 4 cycles, then grant=0010 with preempt=1 for one cycle, then token=0100. Without the macro, grant stays 0001 for 20+ cycles and preempt stays 0.
- Sole requester (macro defined, MAX_HOLD=4): req=0100 held for 12 cycles → grant stays 0100, preempt never asserts.
- Reset mid-tenure: grant=0100 held, reset=1 for 1 edge → grant=0000 and token=0001 after that edge. With req=0100 still high, grant=0100 again one edge after reset drops.

Source files
------------

// File: rtl/ring_token_arbiter.sv
// Four-way round-robin arbiter with a rotating one-hot priority token.
// Define RING_ARB_TIMEOUT_EN to force re-arbitration after MAX_HOLD cycles.
module ring_token_arbiter #(
  parameter int MAX_HOLD = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] owner,
  output logic       busy,
  output logic [3:0] token,
  output logic       preempt
);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] grant_q, grant_d;
  logic [3:0] token_q, token_d;
  logic [1:0] owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       preempt_q, preempt_d;

  logic       timeout;
  logic [3:0] mask;
  logic [3:0] win;
  logic [1:0] win_idx;
  logic       found;
  logic [1:0] tok_idx;

  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("MAX_HOLD must be within 2..255");
  end

  function automatic logic [1:0] enc(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    unique case (1'b1)
      v[0]:    r = 2'd0;
      v[1]:    r = 2'd1;
      v[2]:    r = 2'd2;
      v[3]:    r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

`ifdef RING_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(MAX_HOLD - 1);

  assign timeout = (state_q == HELD) &&
                   req[owner_q] &&
                   (cnt_q == HOLD_LAST);
`else
  assign timeout = 1'b0;
`endif

  // on a timeout the current owner sits out this arbitration
  assign mask    = timeout ? (req & ~grant_q) : req;
  assign tok_idx = enc(token_q);

  always_comb begin
    logic [1:0] pos;
    win     = '0;
    win_idx = '0;
    found   = 1'b0;
    pos     = '0;
    for (int k = 0; k < 4; k++) begin
      pos = tok_idx + 2'(k);
      if (!found && mask[pos]) begin
        found      = 1'b1;
        win_idx    = pos;
        win[pos]   = 1'b1;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    owner_d   = owner_q;
    token_d   = token_q;
    preempt_d = 1'b0;
    cnt_d     = cnt_q;
    if (state_q == HELD && cnt_q != 8'hFF)
      cnt_d = cnt_q + 8'd1;

    unique case (state_q)
      IDLE: begin
        if (found) begin
          state_d = HELD;
          grant_d = win;
          owner_d = win_idx;
          token_d = {win[2:0], win[3]};
          cnt_d   = '0;
        end
      end
      HELD: begin
        if (!req[owner_q]) begin
          if (found) begin
            grant_d = win;
            owner_d = win_idx;
            token_d = {win[2:0], win[3]};
            cnt_d   = '0;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            cnt_d   = '0;
          end
        end else if (timeout) begin
          cnt_d = '0;
          if (found) begin
            grant_d   = win;
            owner_d   = win_idx;
            token_d   = {win[2:0], win[3]};
            preempt_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      grant_q   <= '0;
      owner_q   <= '0;
      token_q   <= 4'b0001;
      cnt_q     <= '0;
      preempt_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      owner_q   <= owner_d;
      token_q   <= token_d;
      cnt_q     <= cnt_d;
      preempt_q <= preempt_d;
    end
  end

  assign grant   = grant_q;
  assign owner   = owner_q;
  assign busy    = (state_q == HELD);
  assign token   = token_q;
  assign preempt = preempt_q;

endmodule

// File: tb/tb_ring_token_arbiter.sv
// Scoreboard bench for ring_token_arbiter; expectations are queued as
// stimulus is driven and popped after each clock edge.
module tb_ring_token_arbiter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] req   = 4'b0000;
  logic [3:0] grant;
  logic [1:0] owner;
  logic       busy;
  logic [3:0] token;
  logic       preempt;

  int n_checks = 0;
  int n_fails  = 0;
  logic [11:0] sb[$];

  ring_token_arbiter #(.MAX_HOLD(4)) dut (
    .clock  (clock),
    .reset  (reset),
    .req    (req),
    .grant  (grant),
    .owner  (owner),
    .busy   (busy),
    .token  (token),
    .preempt(preempt)
  );

  always #5 clock = ~clock;

  // packed view: grant, token, busy, preempt, owner
  function automatic logic [11:0] ev(input logic [3:0] g,
                                     input logic [3:0] t,
                                     input logic p);
    logic [1:0] o;
    o = g[1] ? 2'd1 : g[2] ? 2'd2 : g[3] ? 2'd3 : 2'd0;
    return {g, t, |g, p, o};
  endfunction

  function automatic logic [11:0] obs();
    return {grant, token, busy, preempt, busy ? owner : 2'b00};
  endfunction

  task automatic drive(input logic r, input logic [3:0] q,
                       input logic [11:0] e);
    reset = r;
    req   = q;
    sb.push_back(e);
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    logic [11:0] e;
    for (int i = 0; i < 4; i++) begin
      if (i < 2) drive(1'b1, 4'b1111, ev(4'b0000, 4'b0001, 1'b0));
      else       drive(1'b0, 4'b1111, ev(4'b0001, 4'b0010, 1'b0));
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL reset row %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_handover();
    logic [3:0]  rq[5] = '{4'b0000, 4'b1010, 4'b1000,
                           4'b0000, 4'b0000};
    logic        rs[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    logic [11:0] ex[5];
    logic [11:0] e;
    ex[0] = ev(4'b0000, 4'b0001, 1'b0);
    ex[1] = ev(4'b0010, 4'b0100, 1'b0);
    ex[2] = ev(4'b1000, 4'b0001, 1'b0);
    ex[3] = ev(4'b0000, 4'b0001, 1'b0);
    ex[4] = ev(4'b0000, 4'b0001, 1'b0);
    for (int i = 0; i < 5; i++) begin
      drive(rs[i], rq[i], ex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL handover row %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_wrap_idle();
    logic [3:0]  rq[6] = '{4'b0000, 4'b0100, 4'b0000,
                           4'b1001, 4'b0001, 4'b0000};
    logic [11:0] ex[6];
    logic [11:0] e;
    ex[0] = ev(4'b0000, 4'b0001, 1'b0);
    ex[1] = ev(4'b0100, 4'b1000, 1'b0);
    ex[2] = ev(4'b0000, 4'b1000, 1'b0);
    ex[3] = ev(4'b1000, 4'b0001, 1'b0);
    ex[4] = ev(4'b0001, 4'b0010, 1'b0);
    ex[5] = ev(4'b0000, 4'b0010, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, rq[i], ex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL wrap_idle row %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_hold_ignore();
    logic [3:0]  rq[6] = '{4'b0000, 4'b0001, 4'b0011,
                           4'b0111, 4'b0110, 4'b0000};
    logic [11:0] ex[6];
    logic [11:0] e;
    ex[0] = ev(4'b0000, 4'b0001, 1'b0);
    ex[1] = ev(4'b0001, 4'b0010, 1'b0);
    ex[2] = ev(4'b0001, 4'b0010, 1'b0);
    ex[3] = ev(4'b0001, 4'b0010, 1'b0);
    ex[4] = ev(4'b0010, 4'b0100, 1'b0);
    ex[5] = ev(4'b0000, 4'b0100, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, rq[i], ex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL hold_ignore row %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  rq[6] = '{4'b0000, 4'b1111, 4'b1110,
                           4'b1100, 4'b1000, 4'b0001};
    logic [11:0] ex[6];
    logic [11:0] e;
    ex[0] = ev(4'b0000, 4'b0001, 1'b0);
    ex[1] = ev(4'b0001, 4'b0010, 1'b0);
    ex[2] = ev(4'b0010, 4'b0100, 1'b0);
    ex[3] = ev(4'b0100, 4'b1000, 1'b0);
    ex[4] = ev(4'b1000, 4'b0001, 1'b0);
    ex[5] = ev(4'b0001, 4'b0010, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(i == 0, rq[i], ex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL back_to_back row %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_timeout();
    logic [11:0] e;
    logic [11:0] x;
    drive(1'b1, 4'b0000, ev(4'b0000, 4'b0001, 1'b0));
    e = sb.pop_front();
    n_checks++;
    if (obs() !== e) begin
      n_fails++;
      $display("FAIL timeout reset: g/t/b/p/o got %b want %b", obs(), e);
    end
`ifdef RING_ARB_TIMEOUT_EN
    for (int i = 1; i <= 10; i++) begin
      if (i <= 4)       x = ev(4'b0001, 4'b0010, 1'b0);
      else if (i == 5)  x = ev(4'b0010, 4'b0100, 1'b1);
      else if (i <= 8)  x = ev(4'b0010, 4'b0100, 1'b0);
      else if (i == 9)  x = ev(4'b0001, 4'b0010, 1'b1);
      else              x = ev(4'b0001, 4'b0010, 1'b0);
      drive(1'b0, 4'b0011, x);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL timeout edge %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
`else
    for (int i = 1; i <= 22; i++) begin
      x = ev(4'b0001, 4'b0010, 1'b0);
      drive(1'b0, 4'b0011, x);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL no_timeout edge %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
`endif
  endtask

  task automatic test_sole();
    logic [11:0] e;
    for (int i = 0; i <= 12; i++) begin
      if (i == 0) drive(1'b1, 4'b0000, ev(4'b0000, 4'b0001, 1'b0));
      else        drive(1'b0, 4'b0100, ev(4'b0100, 4'b1000, 1'b0));
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL sole row %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic        rs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [11:0] ex[6];
    logic [11:0] e;
    ex[0] = ev(4'b0000, 4'b0001, 1'b0);
    ex[1] = ev(4'b0100, 4'b1000, 1'b0);
    ex[2] = ev(4'b0100, 4'b1000, 1'b0);
    ex[3] = ev(4'b0100, 4'b1000, 1'b0);
    ex[4] = ev(4'b0000, 4'b0001, 1'b0);
    ex[5] = ev(4'b0100, 4'b1000, 1'b0);
    for (int i = 0; i < 6; i++) begin
      drive(rs[i], (i == 0) ? 4'b0000 : 4'b0100, ex[i]);
      e = sb.pop_front();
      n_checks++;
      if (obs() !== e) begin
        n_fails++;
        $display("FAIL reset_mid row %0d: g/t/b/p/o got %b want %b",
                 i, obs(), e);
      end
    end
  endtask

  initial begin
    @(posedge clock);
    #1;
    test_reset();
    test_handover();
    test_wrap_idle();
    test_hold_ignore();
    test_back_to_back();
    test_timeout();
    test_sole();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fails);
    $finish;
  end

endmodule
